fir_out_conditioner: RTL and testbench
======================================

# fir_out_conditioner

- Sits directly downstream of the 6-tap symmetric DA FIR (12-bit in, 29-bit out, fixed 7-clock latency).
- Pipeline flow:
  - re-aligns a sample-valid strobe with the FIR output;
  - rounds and saturates the 29-bit result back to sample width;
  - optionally decimates;
  - buffers results in a small FIFO with a valid/ready output handshake.
- Also keeps saturation and overrun statistics for the control plane.

## Interface
Parameters:
- FIR_W, 29 — FIR output width.
- FIR_LAT, 7 — clocks from FIR `filter_in` to `filter_out`.
- SHIFT, 17 — right shift applied (the FIR gain is about 2^17).
- OUT_W, 12 — output sample width.
- DECIM, 1 — keep 1 of every DECIM aligned samples (1..256).
- FIFO_DEPTH, 4 — output buffer entries (power of 2, ≥2).

Ports (the clock is a single domain; reset is asynchronous, active-high):
- clk  in  1  — single clock.
- rst  in  1  — asynchronous active-high reset.
- in_valid  in  1  — high in the same cycle a valid sample is driven into the FIR's `filter_in`.
- filter_out  in  FIR_W  — signed FIR result.
- out_data  out  OUT_W  — signed conditioned sample (FIFO head).
- out_valid  out  1  — FIFO non-empty.
- out_ready  in  1  — consumer accepts head when out_valid & out_ready.
- stat_clr  in  1  — synchronous clear of statistics.
- sat_cnt  out  16  — saturation event count; saturates at 0xFFFF.
- overrun  out  1  — sticky flag: a kept sample was dropped because the FIFO was full.

## Operation
- **Alignment:**
  - vld_sr is a FIR_LAT-deep shift register of in_valid.
  - Its tail, aligned_v, qualifies filter_out in the same cycle.
  - filter_out is ignored whenever aligned_v = 0.
- **Rounding:**
  - Sign-extend filter_out to FIR_W+1 bits.
  - Add 2^(SHIFT-1), then arithmetic shift right by SHIFT. This is round-half-up: +0.5 → 1, −0.5 → 0.
- **Saturation:**
  - Clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - A clamp on an aligned, kept sample increments sat_cnt.
- **Decimation:**
  - phase counter runs 0..DECIM−1 and advances on each aligned_v, wrapping to 0.
  - A sample is kept only when phase = 0.
  - With DECIM = 1, every aligned sample is kept.
- **Stage register:** round/saturate result and keep-flag registered into cond_data / cond_v.
- **FIFO:**
  - cond_v writes cond_data; first-word fall-through.
  - Read occurs on out_valid & out_ready.
  - Write while full with no read in the same cycle: sample dropped, overrun set.
  - Full with a read and a write in the same cycle: both succeed, count unchanged.
  - Empty with a write and out_ready high: head appears the next cycle; no bypass.
- **Statistics:**
  - stat_clr zeroes sat_cnt and overrun.
  - If an event occurs in the same cycle, the event is applied after the clear (sat_cnt = 1, overrun = 1).

## Timing
- in_valid at cycle t → aligned_v at t+FIR_LAT → cond_v at t+FIR_LAT+1 → out_valid at t+FIR_LAT+2, i.e. 9 clocks at defaults with an empty FIFO.
- Sustained throughput: one sample per clock while out_ready = 1.
- Reset values:
  - out_valid 0, out_data 0, sat_cnt 0, overrun 0.
  - vld_sr all 0, phase 0, FIFO empty, cond_v 0.
- **Reset mid-operation:**
  - All in-flight valids and FIFO contents are discarded.
  - The FIR datapath (which has no reset) is not touched.
  - The first out_valid after reset requires a new in_valid.
- out_data is stable while out_valid & !out_ready.
- sat_cnt holds at 0xFFFF; it does not wrap.

## Structure
- Package fir_cond_pkg holds:
  - FIR_OUT_W = 29, FIR_LATENCY = 7, FIR_GAIN_SHIFT = 17, SAMPLE_W = 12;
  - a round_sat function (width-parameterised via the constants).
- Sub-module fir_cond_fifo: synchronous FIFO, FWFT, with full/empty, DEPTH/W parameters, asynchronous active-high reset.
- Top level contains the alignment shift register, phase counter, round/sat stage, and statistics.

## Test plan
1. **Impulse:** FIR driven with 2047 for one in_valid cycle, then 0s with valid, out_ready = 1.
   - Required outputs, in order: 118, 319, 512, 512, 319, 118, then 0s.
   - First out_valid arrives 9 clocks after the impulse.
2. **Rounding/saturation:** filter_out forced with aligned_v high.
   - 65536 → 1
   - −65536 → 0
   - 268435455 → 2047, sat_cnt = 1
   - −268435456 → −2048, sat_cnt unchanged
3. **Decimation:** DECIM = 3, 9 consecutive valid DC samples of 1000.
   - Exactly 3 outputs, taken from aligned samples 0, 3 and 6.
   - Steady value 927.
4. **Backpressure:** out_ready = 0, 6 kept samples, FIFO_DEPTH = 4.
   - 4 buffered; overrun = 1 after the 5th.
   - Raising out_ready drains the first 4 in order.
   - Simultaneous read+write while full: no drop.
5. **Reset mid-stream:** rst asserted 2 cycles while 3 samples are in flight.
   - out_valid drops immediately and stays 0 until 9 clocks after the next in_valid.
   - sat_cnt = 0.
6. **stat_clr concurrent with a saturation event:**
   - sat_cnt = 1 afterwards.
   - stat_clr alone → sat_cnt = 0, overrun = 0.

Source files
------------

// File: rtl/fir_cond_pkg.sv
// Shared constants and the round/saturate helper for the FIR output conditioner.
package fir_cond_pkg;

    localparam int unsigned FIR_OUT_W      = 29;
    localparam int unsigned FIR_LATENCY    = 7;
    localparam int unsigned FIR_GAIN_SHIFT = 17;
    localparam int unsigned SAMPLE_W       = 12;

    // Working width for the rounding arithmetic; wide enough for any sane FIR result.
    localparam int unsigned RS_W = 64;

    // Round-half-up by 2^shift, then clamp to a signed out_w-bit range.
    // The caller truncates the result to out_w bits; sat flags a clamp.
    function automatic logic signed [RS_W-1:0] round_sat(
        input  logic signed [RS_W-1:0] x,
        input  int unsigned            shift,
        input  int unsigned            out_w,
        output logic                   sat
    );
        logic signed [RS_W-1:0] half;
        logic signed [RS_W-1:0] r;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        half = 64'sd1 <<< (shift - 1);
        r    = (x + half) >>> shift;
        hi   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo   = -(64'sd1 <<< (out_w - 1));
        sat  = 1'b0;
        if (r > hi) begin
            r   = hi;
            sat = 1'b1;
        end else if (r < lo) begin
            r   = lo;
            sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_cond_fifo.sv
// Small synchronous first-word-fall-through FIFO for conditioned samples.
module fir_cond_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          do_wr;
    logic          do_rd;

    // A write while full only lands if the head is read in the same cycle.
    always_comb begin
        do_rd     = rd_en && !empty;
        do_wr     = wr_en && (!full || do_rd);
        count_nxt = count;
        if (do_wr && !do_rd) begin
            count_nxt = count + (AW+1)'(1);
        end else if (!do_wr && do_rd) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    // Pointers, occupancy and registered empty/full flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == (AW+1)'(DEPTH));
        end
    end

    // Storage; cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fir_out_conditioner.sv
// Aligns, rounds, saturates, decimates and buffers the DA FIR output stream.
module fir_out_conditioner
    import fir_cond_pkg::*;
#(
    parameter int unsigned FIR_W      = FIR_OUT_W,
    parameter int unsigned FIR_LAT    = FIR_LATENCY,
    parameter int unsigned SHIFT      = FIR_GAIN_SHIFT,
    parameter int unsigned OUT_W      = SAMPLE_W,
    parameter int unsigned DECIM      = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [FIR_W-1:0] filter_out,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             stat_clr,
    output logic [15:0]      sat_cnt,
    output logic             overrun
);

    localparam int unsigned PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [FIR_LAT-1:0]     vld_sr;
    logic                   aligned_v;
    logic                   keep;
    logic [PH_W-1:0]        phase;
    logic signed [RS_W-1:0] fo_ext;
    logic [OUT_W-1:0]       rs_data;
    logic                   rs_sat;
    logic [OUT_W-1:0]       cond_data;
    logic                   cond_v;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   rd_fire;
    logic                   sat_ev;
    logic                   ov_ev;

    assign aligned_v = vld_sr[FIR_LAT-1];
    assign keep      = aligned_v && (phase == '0);
    assign rd_fire   = !fifo_empty && out_ready;
    assign sat_ev    = keep && rs_sat;
    assign ov_ev     = cond_v && fifo_full && !rd_fire;
    assign out_valid = !fifo_empty;

    // Delay in_valid by the FIR latency so it lines up with filter_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_sr <= '0;
        else     vld_sr <= {vld_sr[FIR_LAT-2:0], in_valid};
    end

    // Decimation phase advances on every aligned sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (aligned_v) begin
            if (phase == PH_W'(DECIM - 1)) phase <= '0;
            else                           phase <= phase + PH_W'(1);
        end
    end

    // Sign-extend, round and clamp the FIR result to sample width.
    always_comb begin
        rs_sat  = 1'b0;
        fo_ext  = RS_W'($signed(filter_out));
        rs_data = OUT_W'(round_sat(fo_ext, SHIFT, OUT_W, rs_sat));
    end

    // Stage register between the arithmetic and the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cond_v    <= 1'b0;
            cond_data <= '0;
        end else begin
            cond_v <= keep;
            if (keep) cond_data <= rs_data;
        end
    end

    // Saturation counter; a clear takes effect before a same-cycle event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (stat_clr) begin
            sat_cnt <= sat_ev ? 16'd1 : 16'd0;
        end else if (sat_ev && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

    // Sticky overrun flag; a clear takes effect before a same-cycle drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           overrun <= 1'b0;
        else if (stat_clr) overrun <= ov_ev;
        else if (ov_ev)    overrun <= 1'b1;
    end

    fir_cond_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (OUT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cond_v),
        .wr_data (cond_data),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_fir_out_conditioner.sv
// Scoreboard bench for fir_out_conditioner with a behavioural 6-tap FIR in front.
module tb_fir_out_conditioner;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst3;
    logic        rst3_hold;
    logic        in_valid;
    logic [28:0] filter_out;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        stat_clr;
    logic [15:0] sat_cnt;
    logic        overrun;
    logic [11:0] out_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [15:0] sat_cnt3;
    logic        overrun3;

    int errors = 0;
    int checks = 0;
    int cnt3   = 0;

    logic [11:0] sb  [$];
    logic [11:0] sb3 [$];

    // Behavioural FIR: taps on the live sample, then a 7-clock delay to filter_out.
    int          taps [6] = '{7556, 20426, 32768, 32768, 20426, 7556};
    int          hist [5] = '{default: 0};
    logic [28:0] fir_y = '0;
    logic [28:0] dl [7];

    always #5 clk = ~clk;

    assign rst3 = rst | rst3_hold;

    always @(posedge clk) begin
        dl[0] <= fir_y;
        for (int i = 1; i < 7; i++) dl[i] <= dl[i-1];
    end
    assign filter_out = dl[6];

    fir_out_conditioner #(.DECIM(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .filter_out(filter_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .stat_clr(stat_clr), .sat_cnt(sat_cnt), .overrun(overrun)
    );

    fir_out_conditioner #(.DECIM(3), .FIFO_DEPTH(4)) dut3 (
        .clk(clk), .rst(rst3), .in_valid(in_valid), .filter_out(filter_out),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .stat_clr(stat_clr), .sat_cnt(sat_cnt3), .overrun(overrun3)
    );

    // Reference rounding: floor((y + 2^16) / 2^17) with explicit floor, then clamp.
    function automatic int ref_rs(input longint y);
        longint q;
        q = y + 64'sd65536;
        if (q >= 0) q = q / 131072;
        else        q = -((-q + 131071) / 131072);
        if (q > 2047)  q = 2047;
        if (q < -2048) q = -2048;
        return int'(q);
    endfunction

    // Scoreboard for the DECIM=1 instance: every accepted head is popped and compared.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected out_data=%0d with nothing expected", $signed(out_data));
            end else begin
                logic [11:0] e;
                e = sb.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL sb_data got=%0d exp=%0d", $signed(out_data), $signed(e));
                end
            end
        end
    end

    // Scoreboard for the DECIM=3 instance.
    always @(negedge clk) begin
        if (!rst3 && out_valid3 && out_ready3) begin
            cnt3++;
            checks++;
            if (sb3.size() == 0) begin
                errors++;
                $display("FAIL sb3_unexpected out_data3=%0d with nothing expected", $signed(out_data3));
            end else begin
                logic [11:0] e;
                e = sb3.pop_front();
                if (out_data3 !== e) begin
                    errors++;
                    $display("FAIL sb3_data got=%0d exp=%0d", $signed(out_data3), $signed(e));
                end
            end
        end
    end

    // One clock of stimulus: FIR input x (or a forced FIR result), optional model push.
    task automatic tick(input bit v, input int x, input bit fen, input int fval, input bit push);
        longint y;
        int     e;
        @(posedge clk);
        #1;
        y = longint'(taps[0]) * x;
        for (int k = 1; k < 6; k++) y += longint'(taps[k]) * hist[k-1];
        for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
        if (fen) y = longint'(fval);
        fir_y    = 29'(y);
        in_valid = v;
        if (v && push) begin
            e = ref_rs(y);
            sb.push_back(e[11:0]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        idle(3);
        @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_sat_cnt", int'(sat_cnt), 0);
        chk("reset_overrun", int'(overrun), 0);
        tick(1'b0, 0, 1'b0, 0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_impulse();
        int exp_imp [8] = '{118, 319, 512, 512, 319, 118, 0, 0};
        out_ready = 1'b1;
        idle(6);
        tick(1'b1, 2047, 1'b0, 0, 1'b0);
        for (int i = 0; i < 8; i++) sb.push_back(12'(exp_imp[i]));
        for (int k = 1; k <= 9; k++) begin
            if (k <= 7) tick(1'b1, 0, 1'b0, 0, 1'b0);
            else        idle(1);
            @(negedge clk);
            chk($sformatf("impulse_latency_k%0d", k), int'(out_valid), (k == 9) ? 1 : 0);
        end
        idle(10);
        chk("impulse_drained", sb.size(), 0);
    endtask

    task automatic test_round_sat();
        int vals [4] = '{65536, -65536, 268435455, -268435456};
        int outs [4] = '{1, 0, 2047, -2048};
        int sats [4] = '{0, 0, 1, 1};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 0, 1'b1, vals[i], 1'b0);
            sb.push_back(12'(outs[i]));
            idle(11);
            @(negedge clk);
            chk($sformatf("round_sat_cnt_%0d", i), int'(sat_cnt), sats[i]);
            chk($sformatf("round_sat_drained_%0d", i), sb.size(), 0);
        end
    endtask

    task automatic test_decim();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick(1'b0, 1000, 1'b0, 0, 1'b0);
        rst3_hold = 1'b0;
        cnt3      = 0;
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, 1000, 1'b0, 0, 1'b1);
            if (i % 3 == 0) sb3.push_back(12'd927);
        end
        for (int i = 0; i < 12; i++) tick(1'b0, 1000, 1'b0, 0, 1'b0);
        @(negedge clk);
        chk("decim_count", cnt3, 3);
        chk("decim_sb3_drained", sb3.size(), 0);
        chk("decim_sb_drained", sb.size(), 0);
        chk("decim_sat_cnt3", int'(sat_cnt3), 0);
        chk("decim_overrun3", int'(overrun3), 0);
        rst3_hold = 1'b1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) tick(1'b1, 0, 1'b1, i << 17, 1'b1);
        idle(9);
        @(negedge clk);
        chk("bp_overrun_before", int'(overrun), 0);
        chk("bp_valid_full", int'(out_valid), 1);
        chk("bp_head_stable_a", int'(out_data), 1);
        tick(1'b1, 0, 1'b1, 5 << 17, 1'b0);
        idle(9);
        @(negedge clk);
        chk("bp_overrun_after_5th", int'(overrun), 1);
        tick(1'b1, 0, 1'b1, 6 << 17, 1'b0);
        idle(9);
        @(negedge clk);
        chk("bp_head_stable_b", int'(out_data), 1);
        chk("bp_queued", sb.size(), 4);
        out_ready = 1'b1;
        idle(6);
        @(negedge clk);
        chk("bp_drained", sb.size(), 0);
        chk("bp_empty", int'(out_valid), 0);

        // Simultaneous read and write while full.
        idle(1);
        stat_clr = 1'b1;
        idle(1);
        stat_clr = 1'b0;
        @(negedge clk);
        chk("bp_overrun_cleared", int'(overrun), 0);
        out_ready = 1'b0;
        for (int i = 11; i <= 14; i++) tick(1'b1, 0, 1'b1, i << 17, 1'b1);
        idle(9);
        tick(1'b1, 0, 1'b1, 15 << 17, 1'b1);
        idle(8);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        idle(3);
        @(negedge clk);
        chk("bp_rw_full_no_overrun", int'(overrun), 0);
        chk("bp_rw_full_queued", sb.size(), 4);
        out_ready = 1'b1;
        idle(6);
        @(negedge clk);
        chk("bp_rw_full_drained", sb.size(), 0);
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        tick(1'b1, 0, 1'b1, 268435455, 1'b1);
        idle(10);
        @(negedge clk);
        chk("rst_mid_valid_before", int'(out_valid), 1);
        for (int i = 0; i < 3; i++) tick(1'b1, 0, 1'b1, 5 << 17, 1'b1);
        idle(2);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid_drop", int'(out_valid), 0);
        idle(2);
        rst = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_sat_cnt", int'(sat_cnt), 0);
        chk("rst_mid_overrun", int'(overrun), 0);
        for (int k = 0; k < 12; k++) begin
            idle(1);
            @(negedge clk);
            chk($sformatf("rst_mid_quiet_%0d", k), int'(out_valid), 0);
        end
        tick(1'b1, 0, 1'b1, 7 << 17, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            idle(1);
            @(negedge clk);
            chk($sformatf("rst_mid_relatency_k%0d", k), int'(out_valid), (k == 9) ? 1 : 0);
        end
        idle(3);
        chk("rst_mid_drained", sb.size(), 0);
    endtask

    task automatic test_stat_clr();
        out_ready = 1'b1;
        tick(1'b1, 0, 1'b1, 268435455, 1'b1);
        idle(10);
        @(negedge clk);
        chk("clr_pre_sat_cnt", int'(sat_cnt), 1);
        // Saturating sample aligned in the same cycle as stat_clr.
        tick(1'b1, 0, 1'b1, 268435455, 1'b1);
        idle(7);
        stat_clr = 1'b1;
        idle(1);
        stat_clr = 1'b0;
        idle(3);
        @(negedge clk);
        chk("clr_concurrent_sat_cnt", int'(sat_cnt), 1);

        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) tick(1'b1, 0, 1'b1, (20 + i) << 17, (i <= 4) ? 1'b1 : 1'b0);
        idle(12);
        @(negedge clk);
        chk("clr_pre_overrun", int'(overrun), 1);
        idle(1);
        stat_clr = 1'b1;
        idle(1);
        stat_clr = 1'b0;
        @(negedge clk);
        chk("clr_alone_sat_cnt", int'(sat_cnt), 0);
        chk("clr_alone_overrun", int'(overrun), 0);
        out_ready = 1'b1;
        idle(6);
        chk("clr_drained", sb.size(), 0);
    endtask

    initial begin
        rst        = 1'b1;
        rst3_hold  = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        out_ready3 = 1'b1;
        stat_clr   = 1'b0;
        for (int i = 0; i < 7; i++) dl[i] = '0;

        test_reset();
        test_impulse();
        test_round_sat();
        test_decim();
        test_backpressure();
        test_reset_midstream();
        test_stat_clr();

        idle(4);
        chk("final_sb_empty", sb.size(), 0);
        chk("final_sb3_empty", sb3.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
